rally_referee: RTL and testbench
================================

Name: rally_referee

Overview:
- Frame-rate judge that produces the per-rally point event (`point_valid`, `winner`) consumed by the game-state controller.
- Samples ball position and player-contact flags once per frame-enable pulse and detects a floor landing or a touch-limit fault.
- Issues one point pulse, then holds a post-point freeze window of `FREEZE_FRAMES` frames before signalling the round is done.
- Sits between the render/physics outputs (ball coordinates, cover flags) and the top-level game FSM.

Parameters:
- BALL_SIZE, 40: ball sprite width/height in pixels; `ball_x`/`ball_y` give its top-left corner.
- FLOOR_Y, 352: landing line; the ball has landed when ball_y + BALL_SIZE >= FLOOR_Y.
- NET_X, 320: net x position; ball centre < NET_X means P1 side, otherwise P2 side.
- MAX_TOUCH, 3: maximum consecutive touches per side; 0 disables the touch-fault check.
- FREEZE_FRAMES, 90: length of the post-point freeze in frames; a value of 0 behaves as 1.

Ports:
- clk  input  1  system clock, 100 MHz.
- reset_n  input  1  synchronous, active-low reset.
- frame_en  input  1  one-cycle pulse per game frame (60 Hz).
- round_start  input  1  one-cycle pulse that begins a rally.
- round_abort  input  1  synchronous return to IDLE; no point is issued.
- ball_x  input  10  ball top-left x, in pixels.
- ball_y  input  10  ball top-left y, in pixels.
- p1_cover  input  1  level: P1 sprite overlaps the ball.
- p2_cover  input  1  level: P2 sprite overlaps the ball.
- point_valid  output  1  one-cycle point pulse.
- winner  output  2  1 = P1, 2 = P2, 0 = none; holds until the next point.
- freeze  output  1  high during the post-point freeze.
- round_done  output  1  one-cycle pulse when the freeze ends.
- in_rally  output  1  high while in RALLY.

Behaviour:
- **Reset** (reset_n=0 at a clk edge):
  - state = IDLE.
  - All outputs 0: point_valid, winner, freeze, round_done, in_rally.
  - Touch counters and cover history cleared.
  - Applies from any state, including mid-freeze.
- **Arithmetic:**
  - cx = ball_x + BALL_SIZE/2 and by = ball_y + BALL_SIZE, both computed at 11 bits (no wrap).
  - Touch counters are 3 bits and saturate at 7.
- **IDLE:**
  - round_start -> RALLY; in_rally=1; both touch counters = 0.
  - Cover history loaded with the current p1_cover/p2_cover.
- **RALLY** (acts only on cycles with frame_en=1), checks in priority order:
  1. Landed (by >= FLOOR_Y): winner = (cx < NET_X) ? 2 : 1. cx == NET_X counts as P2 side, so winner = 1.
  2. Touch update on rising edges of the cover flags, relative to the value sampled at the previous frame_en:
     - P1 rise only: p1_cnt+1, p2_cnt=0.
     - P2 rise only: p2_cnt+1, p1_cnt=0.
     - Both rise: both counters = 0 (block contact).
  3. Fault, if MAX_TOUCH != 0 and the post-update count exceeds MAX_TOUCH: the fouling side loses (p1_cnt over -> winner 2; p2_cnt over -> winner 1).
  - Landing takes priority over a fault in the same frame; touch counting is skipped that frame.
  - On a point: at that edge state -> SCORED, point_valid=1, winner updated, in_rally=0.
  - Cover history updates every frame_en.
- **SCORED** (exactly one cycle; frame_en ignored):
  - Next edge: point_valid=0, freeze=1, cnt=max(FREEZE_FRAMES,1), state -> FREEZE.
- **FREEZE:**
  - On each frame_en: if cnt == 1 then freeze=0, round_done=1 (one cycle), state -> IDLE; else cnt-1.
  - round_start is ignored here.
- **Latency:**
  - point_valid is high in the cycle immediately after the deciding frame_en cycle.
  - freeze rises one cycle after point_valid.
  - round_done occurs on the FREEZE_FRAMES-th frame_en after freeze rises.
- **round_abort:**
  - In any non-IDLE state: next edge -> IDLE.
  - Clears freeze and in_rally; point_valid and round_done forced 0; winner retained.
  - round_abort and round_start in the same cycle: abort wins.
- **Misc:**
  - round_start while in RALLY is ignored.
  - frame_en and round_start in the same IDLE cycle: only the transition occurs; no frame evaluation that cycle.

Test Plan:
1. Reset, round_start, then frame_en with ball_x=100, ball_y=320 (by=360) -> point_valid pulse next cycle, winner=2, freeze high the following cycle.
2. ball_x=300 (cx=320), ball_y=312 -> winner=1 (net-centre tie counts as P2 side).
3. MAX_TOUCH=3, four separate P1 cover rising edges with ball airborne -> point after the 4th, winner=2. Interleave one P2 touch after the 3rd -> no point.
4. Same frame: landing on P2 side and 4th P1 touch -> winner=1 (landing priority).
5. FREEZE_FRAMES=90 -> round_done exactly on the 90th frame_en after freeze rises; round_start during the freeze is ignored.
6. round_abort mid-freeze at frame 40 -> freeze=0, IDLE next cycle, winner retained. reset_n=0 mid-RALLY -> all outputs 0.

Source files
------------

// File: rtl/rally_referee_if.sv
// Handshake bundle between the rally referee and its surroundings: physics/render inputs in,
// point/freeze events out to the game FSM.
interface rally_referee_if;
  logic       frame_en;
  logic       round_start;
  logic       round_abort;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       p1_cover;
  logic       p2_cover;
  logic       point_valid;
  logic [1:0] winner;
  logic       freeze;
  logic       round_done;
  logic       in_rally;

  modport master (
    output frame_en, round_start, round_abort, ball_x, ball_y, p1_cover, p2_cover,
    input  point_valid, winner, freeze, round_done, in_rally
  );

  modport slave (
    input  frame_en, round_start, round_abort, ball_x, ball_y, p1_cover, p2_cover,
    output point_valid, winner, freeze, round_done, in_rally
  );
endinterface

// File: rtl/rally_referee.sv
// Frame-rate rally judge: detects a floor landing or a touch-limit fault, pulses one point
// event, then holds a post-point freeze before signalling the round is done.
module rally_referee #(
  parameter int unsigned BALL_SIZE     = 40,
  parameter int unsigned FLOOR_Y       = 352,
  parameter int unsigned NET_X         = 320,
  parameter int unsigned MAX_TOUCH     = 3,
  parameter int unsigned FREEZE_FRAMES = 90
) (
  input logic            clk,
  input logic            reset_n,
  rally_referee_if.slave bus_io
);

  localparam int unsigned FreezeLoad = (FREEZE_FRAMES == 0) ? 1 : FREEZE_FRAMES;
  localparam int unsigned CntW       = $clog2(FreezeLoad + 1);

  typedef enum logic [1:0] {StIdle, StRally, StScored, StFreeze} state_e;

  state_e          state_q;
  logic [2:0]      p1_cnt_q, p2_cnt_q;
  logic            p1_hist_q, p2_hist_q;
  logic [CntW-1:0] frz_cnt_q;
  logic            point_valid_q, freeze_q, round_done_q, in_rally_q;
  logic [1:0]      winner_q;

  logic [10:0] cx, by;
  logic        landed, p1_rise, p2_rise, p1_fault, p2_fault;
  logic [2:0]  p1_cnt_d, p2_cnt_d;

  always_comb begin
    cx       = {1'b0, bus_io.ball_x} + 11'(BALL_SIZE / 2);
    by       = {1'b0, bus_io.ball_y} + 11'(BALL_SIZE);
    landed   = (by >= 11'(FLOOR_Y));
    p1_rise  = bus_io.p1_cover & ~p1_hist_q;
    p2_rise  = bus_io.p2_cover & ~p2_hist_q;
    p1_cnt_d = p1_cnt_q;
    p2_cnt_d = p2_cnt_q;
    case ({p1_rise, p2_rise})
      2'b10: begin
        p1_cnt_d = (p1_cnt_q == 3'd7) ? 3'd7 : p1_cnt_q + 3'd1;
        p2_cnt_d = 3'd0;
      end
      2'b01: begin
        p2_cnt_d = (p2_cnt_q == 3'd7) ? 3'd7 : p2_cnt_q + 3'd1;
        p1_cnt_d = 3'd0;
      end
      // Simultaneous contact is a block: neither side is charged a touch.
      2'b11: begin
        p1_cnt_d = 3'd0;
        p2_cnt_d = 3'd0;
      end
      default: ;
    endcase
    p1_fault = (MAX_TOUCH != 0) && ({29'd0, p1_cnt_d} > MAX_TOUCH);
    p2_fault = (MAX_TOUCH != 0) && ({29'd0, p2_cnt_d} > MAX_TOUCH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      p1_cnt_q      <= 3'd0;
      p2_cnt_q      <= 3'd0;
      p1_hist_q     <= 1'b0;
      p2_hist_q     <= 1'b0;
      frz_cnt_q     <= '0;
      point_valid_q <= 1'b0;
      winner_q      <= 2'd0;
      freeze_q      <= 1'b0;
      round_done_q  <= 1'b0;
      in_rally_q    <= 1'b0;
    end else begin
      point_valid_q <= 1'b0;
      round_done_q  <= 1'b0;
      // Abort outranks everything, including a start in the same cycle.
      if (bus_io.round_abort) begin
        state_q    <= StIdle;
        freeze_q   <= 1'b0;
        in_rally_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus_io.round_start) begin
              state_q    <= StRally;
              in_rally_q <= 1'b1;
              p1_cnt_q   <= 3'd0;
              p2_cnt_q   <= 3'd0;
              p1_hist_q  <= bus_io.p1_cover;
              p2_hist_q  <= bus_io.p2_cover;
            end
          end
          StRally: begin
            if (bus_io.frame_en) begin
              p1_hist_q <= bus_io.p1_cover;
              p2_hist_q <= bus_io.p2_cover;
              if (landed) begin
                state_q       <= StScored;
                point_valid_q <= 1'b1;
                in_rally_q    <= 1'b0;
                winner_q      <= (cx < 11'(NET_X)) ? 2'd2 : 2'd1;
              end else begin
                p1_cnt_q <= p1_cnt_d;
                p2_cnt_q <= p2_cnt_d;
                if (p1_fault || p2_fault) begin
                  state_q       <= StScored;
                  point_valid_q <= 1'b1;
                  in_rally_q    <= 1'b0;
                  winner_q      <= p1_fault ? 2'd2 : 2'd1;
                end
              end
            end
          end
          StScored: begin
            state_q   <= StFreeze;
            freeze_q  <= 1'b1;
            frz_cnt_q <= CntW'(FreezeLoad);
          end
          StFreeze: begin
            if (bus_io.frame_en) begin
              if (frz_cnt_q == CntW'(1)) begin
                state_q      <= StIdle;
                freeze_q     <= 1'b0;
                round_done_q <= 1'b1;
              end else begin
                frz_cnt_q <= frz_cnt_q - CntW'(1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus_io.point_valid = point_valid_q;
  assign bus_io.winner      = winner_q;
  assign bus_io.freeze      = freeze_q;
  assign bus_io.round_done  = round_done_q;
  assign bus_io.in_rally    = in_rally_q;

endmodule

// File: tb/tb_rally_referee.sv
// Directed bench for rally_referee: per-cycle vector table plus hand-built freeze/abort/reset
// sequences; expectations are written out by hand.
module tb_rally_referee;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rally_referee_if bus ();

  rally_referee dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus_io (bus)
  );

  // One record = inputs for one clock cycle plus the outputs required just after that edge.
  typedef struct packed {
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       fe;
    logic [9:0] bx;
    logic [9:0] by;
    logic       p1;
    logic       p2;
    logic [5:0] exp;  // {point_valid, winner, freeze, round_done, in_rally}
  } vec_t;

  int   n_run  = 0;
  int   n_fail = 0;
  vec_t vq[$];

  function automatic vec_t mk(input logic rs, st, ab, fe, input logic [9:0] bx, by,
                              input logic p1, p2, input logic [5:0] ex);
    vec_t v;
    v.rst_n = rs; v.start = st; v.abort = ab; v.fe = fe;
    v.bx = bx; v.by = by; v.p1 = p1; v.p2 = p2; v.exp = ex;
    return v;
  endfunction

  function automatic vec_t fr(input logic p1, p2, input logic [5:0] ex);
    return mk(1'b1, 1'b0, 1'b0, 1'b1, 10'd100, 10'd100, p1, p2, ex);
  endfunction
  function automatic vec_t nf(input logic p1, p2, input logic [5:0] ex);
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 10'd100, 10'd100, p1, p2, ex);
  endfunction
  function automatic vec_t land(input logic [9:0] bx, by, input logic p1, p2,
                                input logic [5:0] ex);
    return mk(1'b1, 1'b0, 1'b0, 1'b1, bx, by, p1, p2, ex);
  endfunction
  function automatic vec_t st(input logic [5:0] ex);
    return mk(1'b1, 1'b1, 1'b0, 1'b0, 10'd100, 10'd100, 1'b0, 1'b0, ex);
  endfunction
  function automatic vec_t ab(input logic [5:0] ex);
    return mk(1'b1, 1'b0, 1'b1, 1'b0, 10'd100, 10'd100, 1'b0, 1'b0, ex);
  endfunction

  // Expected-output shorthands: in rally, idle, point pulse, frozen.
  function automatic logic [5:0] ir(input logic [1:0] w); return {1'b0, w, 3'b001}; endfunction
  function automatic logic [5:0] id(input logic [1:0] w); return {1'b0, w, 3'b000}; endfunction
  function automatic logic [5:0] pt(input logic [1:0] w); return {1'b1, w, 3'b000}; endfunction
  function automatic logic [5:0] fz(input logic [1:0] w); return {1'b0, w, 3'b100}; endfunction

  task automatic step(input vec_t v, input string tag);
    logic [5:0] act;
    reset_n         = v.rst_n;
    bus.round_start = v.start;
    bus.round_abort = v.abort;
    bus.frame_en    = v.fe;
    bus.ball_x      = v.bx;
    bus.ball_y      = v.by;
    bus.p1_cover    = v.p1;
    bus.p2_cover    = v.p2;
    @(posedge clk);
    #1;
    act = {bus.point_valid, bus.winner, bus.freeze, bus.round_done, bus.in_rally};
    n_run++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s: pv/win/frz/rd/in got %b required %b", tag, act, v.exp);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.round_start = 1'b0;
    bus.round_abort = 1'b0;
    bus.frame_en    = 1'b0;
    bus.ball_x      = 10'd0;
    bus.ball_y      = 10'd0;
    bus.p1_cover    = 1'b0;
    bus.p2_cover    = 1'b0;

    // Reset state
    vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 6'b0));
    vq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 6'b0));
    // Landing on P1 side -> P2 wins; freeze one cycle after the pulse
    vq.push_back(st(ir(2'd0)));
    vq.push_back(land(10'd100, 10'd320, 1'b0, 1'b0, pt(2'd2)));
    vq.push_back(nf(1'b0, 1'b0, fz(2'd2)));
    vq.push_back(ab(id(2'd2)));
    // Centre exactly on the net counts as P2 side; by == FLOOR_Y is a landing
    vq.push_back(st(ir(2'd2)));
    vq.push_back(land(10'd300, 10'd312, 1'b0, 1'b0, pt(2'd1)));
    vq.push_back(nf(1'b0, 1'b0, fz(2'd1)));
    vq.push_back(ab(id(2'd1)));
    // Abort and start together in IDLE: stay idle
    vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 10'd100, 10'd100, 1'b0, 1'b0, id(2'd1)));
    // Start with frame_en and a landed ball: only the transition happens
    vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 10'd100, 10'd320, 1'b0, 1'b0, ir(2'd1)));
    // P1 touches with a P2 touch after the 3rd, off-frame toggles, restart ignored, block
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b1, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(nf(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(nf(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(st(ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b1, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd1)));
    vq.push_back(fr(1'b1, 1'b0, pt(2'd2)));
    vq.push_back(nf(1'b0, 1'b0, fz(2'd2)));
    vq.push_back(ab(id(2'd2)));
    // Landing on P2 side in the same frame as a 4th P1 touch: landing wins
    vq.push_back(st(ir(2'd2)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd2)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd2)));
    vq.push_back(fr(1'b1, 1'b0, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd2)));
    vq.push_back(land(10'd400, 10'd320, 1'b1, 1'b0, pt(2'd1)));
    vq.push_back(nf(1'b0, 1'b0, fz(2'd1)));
    vq.push_back(ab(id(2'd1)));
    // One pixel above the floor is still airborne; centre one left of the net is P1 side
    vq.push_back(st(ir(2'd1)));
    vq.push_back(land(10'd299, 10'd311, 1'b0, 1'b0, ir(2'd1)));
    vq.push_back(land(10'd299, 10'd312, 1'b0, 1'b0, pt(2'd2)));
    vq.push_back(nf(1'b0, 1'b0, fz(2'd2)));
    vq.push_back(ab(id(2'd2)));
    // P2 over the limit -> P1 wins
    vq.push_back(st(ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b1, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b1, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b1, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b0, ir(2'd2)));
    vq.push_back(fr(1'b0, 1'b1, pt(2'd1)));
    vq.push_back(nf(1'b0, 1'b0, fz(2'd1)));
    vq.push_back(ab(id(2'd1)));
    // Abort mid-rally
    vq.push_back(st(ir(2'd1)));
    vq.push_back(ab(id(2'd1)));

    for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i));

    // Full freeze: round_done on exactly the 90th frame, restart during freeze ignored
    step(st(ir(2'd1)), "frz_start");
    step(land(10'd100, 10'd320, 1'b0, 1'b0, pt(2'd2)), "frz_point");
    step(nf(1'b0, 1'b0, fz(2'd2)), "frz_rise");
    for (int k = 1; k <= 90; k++) begin
      step(nf(1'b0, 1'b0, fz(2'd2)), $sformatf("frz_gap%0d", k));
      if (k == 45) step(st(fz(2'd2)), "frz_restart_ignored");
      step(fr(1'b0, 1'b0, (k < 90) ? fz(2'd2) : {1'b0, 2'd2, 3'b010}),
           $sformatf("frz_frame%0d", k));
    end
    step(nf(1'b0, 1'b0, id(2'd2)), "rd_one_cycle");
    step(fr(1'b0, 1'b0, id(2'd2)), "idle_after_done");

    // Abort at freeze frame 40 keeps the winner and stops the countdown
    step(st(ir(2'd2)), "ab_start");
    step(land(10'd300, 10'd312, 1'b0, 1'b0, pt(2'd1)), "ab_point");
    step(nf(1'b0, 1'b0, fz(2'd1)), "ab_rise");
    for (int k = 1; k <= 40; k++) step(fr(1'b0, 1'b0, fz(2'd1)), $sformatf("ab_frame%0d", k));
    step(ab(id(2'd1)), "ab_mid_freeze");
    for (int k = 0; k < 3; k++) step(fr(1'b0, 1'b0, id(2'd1)), $sformatf("ab_idle%0d", k));

    // Reset mid-rally and mid-freeze clears every output
    step(st(ir(2'd1)), "rst_start");
    step(fr(1'b1, 1'b0, ir(2'd1)), "rst_rally");
    step(mk(1'b0, 1'b0, 1'b0, 1'b1, 10'd100, 10'd320, 1'b0, 1'b0, 6'b0), "rst_mid_rally");
    step(st(ir(2'd0)), "rst_restart");
    step(land(10'd100, 10'd320, 1'b0, 1'b0, pt(2'd2)), "rst_point");
    step(nf(1'b0, 1'b0, fz(2'd2)), "rst_freeze");
    step(mk(1'b0, 1'b0, 1'b0, 1'b0, 10'd100, 10'd100, 1'b0, 1'b0, 6'b0), "rst_mid_freeze");
    step(fr(1'b0, 1'b0, id(2'd0)), "rst_idle");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
